// File: rtl/lsm_sample_streamer.sv
// rtl/lsm_sample_streamer.sv - path RAM walker feeding (S_t, cashflow) samples to the regression accumulator
// Optional in-the-money filtering is built when ITM_FILTER_EN is defined.
module lsm_sample_streamer #(
   parameter int WIDTH     = 32,
   parameter int QINT      = 16,
   parameter int QFRAC     = 16,
   parameter int N_SAMPLES = 10,
   parameter int ADDR_W    = $clog2(N_SAMPLES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [WIDTH-1:0]  strike,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [WIDTH-1:0]  rd_s,
   input  logic [WIDTH-1:0]  rd_y,
   output logic              valid_out,
   input  logic              ready_in,
   output logic [WIDTH-1:0]  x_out,
   output logic [WIDTH-1:0]  y_out,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   sample_cnt
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE_S} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);

   state_t           state, state_nx;
   logic [WIDTH-1:0] fifo_s0, fifo_s1, fifo_y0, fifo_y1;
   logic [1:0]       fifo_cnt;
   logic             inflight;
   logic             push, pop, push_slot1;
   logic [2:0]       credit;
   logic             unused_cfg;

   assign unused_cfg = (QINT + QFRAC == WIDTH);

`ifdef ITM_FILTER_EN
   logic [WIDTH-1:0] strike_q;
   assign push = inflight & ($signed(rd_s) < $signed(strike_q));
`else
   logic unused_strike;
   assign unused_strike = ^strike;
   assign push = inflight;
`endif

   assign valid_out  = (fifo_cnt != 2'd0);
   assign pop        = valid_out & ready_in;
   assign x_out      = fifo_s0;
   assign y_out      = fifo_y0;
   // Words already queued plus the one returning; a read is issued only if it will fit.
   assign credit     = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
   assign push_slot1 = (fifo_cnt == 2'd2) || ((fifo_cnt == 2'd1) && !pop);

   always_comb begin
      state_nx = state;
      rd_en    = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nx = RUN;
         end
         RUN: begin
            busy  = 1'b1;
            rd_en = (credit < 3'd2);
            if (rd_en && (rd_addr == LAST_ADDR)) state_nx = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (!inflight && (fifo_cnt == 2'd0)) state_nx = DONE_S;
         end
         DONE_S: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         inflight   <= 1'b0;
         rd_addr    <= '0;
         sample_cnt <= '0;
         fifo_cnt   <= 2'd0;
         fifo_s0    <= '0;
         fifo_s1    <= '0;
         fifo_y0    <= '0;
         fifo_y1    <= '0;
`ifdef ITM_FILTER_EN
         strike_q   <= '0;
`endif
      end else begin
         state    <= state_nx;
         inflight <= rd_en;
         if ((state == IDLE) && start) begin
            rd_addr    <= '0;
            sample_cnt <= '0;
`ifdef ITM_FILTER_EN
            strike_q   <= strike;
`endif
         end else begin
            if (rd_en && (rd_addr != LAST_ADDR)) rd_addr <= rd_addr + 1'b1;
            if (pop) sample_cnt <= sample_cnt + 1'b1;
         end
         // Pop shifts the tail forward; a push to slot 0 in the same cycle overrides the shift.
         if (pop) begin
            fifo_s0 <= fifo_s1;
            fifo_y0 <= fifo_y1;
         end
         if (push) begin
            if (push_slot1) begin
               fifo_s1 <= rd_s;
               fifo_y1 <= rd_y;
            end else begin
               fifo_s0 <= rd_s;
               fifo_y0 <= rd_y;
            end
         end
         fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: tb/tb_lsm_sample_streamer.sv
// tb/tb_lsm_sample_streamer.sv - self-checking bench for lsm_sample_streamer (honours ITM_FILTER_EN)
module tb_lsm_sample_streamer;

   localparam int W  = 32;
   localparam int N  = 10;
   localparam int AW = 4;

   localparam logic [W-1:0] K     = 32'h0064_0000;
   localparam logic [W-1:0] S90   = 32'h005A_0000;
   localparam logic [W-1:0] S100  = 32'h0064_0000;
   localparam logic [W-1:0] S110  = 32'h006E_0000;
   localparam logic [W-1:0] S120  = 32'h0078_0000;

   logic          clk, rst, start, rd_en, valid_out, ready_in, busy, done;
   logic [W-1:0]  strike, rd_s, rd_y, x_out, y_out;
   logic [AW-1:0] rd_addr;
   logic [AW:0]   sample_cnt;

   logic [W-1:0]  ram_s [0:15];
   logic [W-1:0]  ram_y [0:15];

   int checks = 0;
   int errors = 0;

   lsm_sample_streamer #(.WIDTH(W), .QINT(16), .QFRAC(16), .N_SAMPLES(N), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .strike(strike),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_s(rd_s), .rd_y(rd_y),
      .valid_out(valid_out), .ready_in(ready_in), .x_out(x_out), .y_out(y_out),
      .busy(busy), .done(done), .sample_cnt(sample_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rd_en) begin
         rd_s <= ram_s[rd_addr];
         rd_y <= ram_y[rd_addr];
      end
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic bit in_money(input logic [W-1:0] s);
`ifdef ITM_FILTER_EN
      return $signed(s) < $signed(strike);
`else
      return 1'b1;
`endif
   endfunction

   // Reference model: run phase (0 idle, 1 active, 2 done cycle), counts of reads issued,
   // samples transferred and words filtered out, plus the expected sample sequence.
   int nxt = 0, last_cur = 0, cur;
   int issued = 0, xfer = 0, dropped = 0, exp_total = 0, done_seen = 0;
   bit prev_rd = 0, prev_drop = 0, start_prev = 0, rst_prev = 0;
   bit prev_valid = 0, prev_ready = 0;
   logic [W-1:0] prev_x, prev_y;
   logic [W-1:0] q_s[$], q_y[$];

   always @(negedge clk) begin : cmp
      int outstanding, occ;
      bit pop_m, exp_rd;
      cur = nxt;
      if (rst_prev) begin
         cur = 0; issued = 0; xfer = 0; dropped = 0; prev_rd = 0; prev_drop = 0;
         q_s.delete(); q_y.delete();
         chk("rst_x_out", x_out, 0);
         chk("rst_y_out", y_out, 0);
         chk("rst_rd_addr", rd_addr, 0);
         chk("rst_sample_cnt", sample_cnt, 0);
      end else if (cur == 0 && last_cur == 0 && start_prev) begin
         cur = 1; issued = 0; xfer = 0; dropped = 0; prev_rd = 0; prev_drop = 0;
         q_s.delete(); q_y.delete();
         for (int i = 0; i < N; i++)
            if (in_money(ram_s[i])) begin
               q_s.push_back(ram_s[i]);
               q_y.push_back(ram_y[i]);
            end
         exp_total = q_s.size();
      end

      outstanding = issued - xfer - dropped;
      occ         = outstanding - int'(prev_rd);
      pop_m       = (occ > 0) && ready_in;
      exp_rd      = (cur == 1) && (issued < N) && (outstanding - int'(pop_m) < 2);

      chk("busy", busy, cur == 1);
      chk("done", done, cur == 2);
      chk("valid_out", valid_out, occ > 0);
      chk("rd_en", rd_en, exp_rd);
      if (rd_en && exp_rd) chk("rd_addr", rd_addr, issued);
      if (cur == 2) begin
         chk("sample_cnt_at_done", sample_cnt, exp_total);
         done_seen++;
      end
      if (prev_valid && !prev_ready && !rst_prev) begin
         chk("stall_valid", valid_out, 1);
         chk("stall_x", x_out, prev_x);
         chk("stall_y", y_out, prev_y);
      end
      if (pop_m && valid_out) begin
         if (q_s.size() == 0) chk("sample_underflow", 1, 0);
         else begin
            chk("x_out", x_out, q_s.pop_front());
            chk("y_out", y_out, q_y.pop_front());
         end
         xfer++;
      end

      dropped   += int'(prev_drop);
      prev_drop  = exp_rd && !in_money(ram_s[issued]);
      prev_rd    = exp_rd;
      issued    += int'(exp_rd);

      if (cur == 2) nxt = 0;
      else if (cur == 1 && issued == N && outstanding == 0 && !exp_rd) nxt = 2;
      else nxt = cur;

      last_cur   = cur;
      prev_valid = valid_out;
      prev_ready = ready_in;
      prev_x     = x_out;
      prev_y     = y_out;
      start_prev = start;
      rst_prev   = rst;
   end

   bit rand_ready = 0;
   always @(posedge clk) begin
      #1;
      if (rand_ready) ready_in = ($urandom_range(0, 9) >= 3);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_start;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      int d0 = done_seen;
      int n  = 0;
      while (done_seen == d0 && n < 300) begin
         tick();
         n++;
      end
      checks++;
      if (done_seen == d0) begin
         errors++;
         $display("FAIL %s: no done within 300 cycles", nm);
      end
      tick();
   endtask

   task automatic load(input int mode);
      for (int i = 0; i < 16; i++) begin
         ram_y[i] = 32'(i);
         case (mode)
            0: ram_s[i] = S90;
            1: ram_s[i] = (i == 4) ? S100 : ((i % 2 == 0) ? S90 : S110);
            default: ram_s[i] = S120;
         endcase
      end
   endtask

   initial begin
      int d0, n;
      rst = 1'b1; start = 1'b0; ready_in = 1'b1; strike = K;
      load(0);
      tick(); tick();
      rst = 1'b0;
      tick();

      // 1: latency and back-to-back samples
      start = 1'b1;
      @(negedge clk);
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk("t1_rd_en_T+1", rd_en, 1);
      chk("t1_valid_T+1", valid_out, 0);
      @(negedge clk);
      chk("t1_valid_T+2", valid_out, 0);
      @(negedge clk);
      chk("t1_valid_T+3", valid_out, 1);
      chk("t1_first_y", y_out, 0);
      chk("t1_first_x", x_out, S90);
      wait_done("t1");
      chk("t1_sample_cnt", sample_cnt, 10);

      // 2: alternating in/out of the money, boundary S_t == strike at addr 4
      load(1);
      do_start();
      wait_done("t2");
`ifdef ITM_FILTER_EN
      chk("t2_sample_cnt", sample_cnt, 4);
`else
      chk("t2_sample_cnt", sample_cnt, 10);
`endif

      // 3: random back-pressure
      load(0);
      rand_ready = 1;
      do_start();
      wait_done("t3");
      rand_ready = 0;
      tick();
      ready_in = 1'b1;
      tick();
      chk("t3_sample_cnt", sample_cnt, 10);

      // 4: start pulses during RUN and DRAIN are ignored
      d0 = done_seen;
      do_start();
      tick(); tick();
      do_start();
      n = 0;
      while (issued < N && n < 100) begin tick(); n++; end
      do_start();
      wait_done("t4");
      repeat (5) tick();
      chk("t4_done_count", done_seen - d0, 1);
      do_start();
      wait_done("t4_second");
      chk("t4_second_cnt", sample_cnt, 10);

      // 5: reset mid-run after the third sample
      do_start();
      n = 0;
      while (xfer < 3 && n < 100) begin tick(); n++; end
      chk("t5_reached_3", xfer >= 3, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      d0 = done_seen;
      repeat (20) tick();
      chk("t5_no_done", done_seen - d0, 0);
      do_start();
      wait_done("t5_rerun");
      chk("t5_rerun_cnt", sample_cnt, 10);

      // 6: every path out of the money
      load(2);
      do_start();
      wait_done("t6");
`ifdef ITM_FILTER_EN
      chk("t6_sample_cnt", sample_cnt, 0);
`else
      chk("t6_sample_cnt", sample_cnt, 10);
`endif

      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
